// File: rtl/dram_burst_writer.sv
// Buffered AXI4 write-burst master: data and command FIFOs feeding one INCR burst at a time.
// Define DRAM_WR_ERRCNT_EN to add the saturating err_cnt output counting non-OKAY write responses.

module dram_burst_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);
    localparam logic [AW:0] FULL_COUNT = AW'(0) + (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module dram_burst_writer #(
    parameter int         DATA_DEPTH = 512,
    parameter int         CMD_DEPTH  = 16,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] data_in,
    input  logic        data_we,
    input  logic [39:0] ctrl_in,
    input  logic        ctrl_we,
    output logic [3:0]  m_axi_awid,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        busy,
    output logic        ovf
`ifdef DRAM_WR_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int CAW = $clog2(CMD_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        ovf_q, ovf_d;

    logic [35:0] data_head;
    logic [DAW:0] data_count;
    logic        data_full, data_empty, data_drop, data_pop;
    logic [39:0] cmd_head;
    logic [CAW:0] cmd_count;
    logic        cmd_full, cmd_empty, cmd_drop, cmd_pop;
    logic [7:0]  cmd_len;
    logic        last_beat;

    dram_burst_fifo #(.WIDTH(36), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (data_we),
        .pop_i   (data_pop),
        .wdata_i (data_in),
        .rdata_o (data_head),
        .count_o (data_count),
        .full_o  (data_full),
        .empty_o (data_empty),
        .drop_o  (data_drop)
    );

    dram_burst_fifo #(.WIDTH(40), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ctrl_we),
        .pop_i   (cmd_pop),
        .wdata_i (ctrl_in),
        .rdata_o (cmd_head),
        .count_o (cmd_count),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .drop_o  (cmd_drop)
    );

    assign cmd_len   = cmd_head[39:32];
    assign last_beat = (beat_q == (len_q - 8'd1));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        cmd_pop       = 1'b0;
        data_pop      = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cmd_empty) begin
                    if (cmd_len == 8'd0) begin
                        cmd_pop = 1'b1;
                    end else if (32'(data_count) >= 32'(cmd_len)) begin
                        // The whole burst is already buffered, so W never stalls on data.
                        cmd_pop = 1'b1;
                        addr_d  = {cmd_head[31:2], 2'b00};
                        len_d   = cmd_len;
                        beat_d  = 8'd0;
                        state_d = S_AW;
                    end
                end
            end
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                m_axi_wvalid = 1'b1;
                m_axi_wlast  = last_beat;
                if (m_axi_wready) begin
                    data_pop = 1'b1;
                    beat_d   = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (data_drop || cmd_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q - 8'd1;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = data_head[31:0];
    assign m_axi_wstrb   = data_head[35:32];
    assign busy          = (state_q != S_IDLE) || !data_empty || !cmd_empty;
    assign ovf           = ovf_q;

`ifdef DRAM_WR_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == S_B) && m_axi_bvalid && (m_axi_bresp != 2'b00) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axi_bresp;
`endif

    // Full flags and counts beyond what the FSM needs are folded away here.
    logic unused_status;
    assign unused_status = data_full ^ cmd_full ^ (^cmd_count);
endmodule
